fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of `IF_ID_Stage` and drives the instruction memory address. It owns the PC/nPC register pair and the +4 sequencing, and applies delayed-branch redirects (one delay slot) from the ID stage. It honours the hazard unit's `pc_enable` and `load_enable` stall signals, and remembers a redirect that arrives while the PC is stalled.

## Interface
- `RESET_PC`, 32'd0: PC value after reset.
- `RESET_NPC`, 32'd4: nPC value after reset.
- `ADDR_W`, 9: instruction-memory address width.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `pc_enable` in 1: from hazard unit; 0 holds PC/nPC.
- `load_enable` in 1: from hazard unit; 0 holds the IF/ID outputs.
- `branch_taken` in 1: ID-stage taken branch/jump, valid this cycle.
- `branch_target` in 32: target address; bits [1:0] ignored (forced 00).
- `imem_addr` out ADDR_W: `pc_out[ADDR_W-1:0]`, combinational.
- `imem_data` in 32: instruction word from combinational instruction memory.
- `pc_out` out 32: current PC.
- `npc_out` out 32: current nPC.
- `if_id_instr` out 32: registered instruction for ID.
- `if_id_pc` out 32: registered PC of `if_id_instr`.
- `if_id_valid` out 1: 1 = `if_id_instr` is a real fetch; 0 = bubble.
- `redirect_pending` out 1: a stalled redirect is held.

## Operation
- States: BOOT, RUN, STALL, STALL_REDIR.
- BOOT
  - Entered on reset; lasts exactly one clock edge after `reset` rises.
  - PC/nPC hold; IF/ID loads NOP (32'h0) with valid=0.
  - Next state is RUN regardless of inputs.
- RUN, `pc_enable`=1, `branch_taken`=0: PC←nPC, nPC←nPC+4.
- RUN, `pc_enable`=1, `branch_taken`=1: PC←nPC (delay slot), nPC←{target[31:2],2'b00}.
- RUN, `pc_enable`=0: PC/nPC hold; go to STALL.
  - If `branch_taken`=1 in that cycle, also latch the target and go to STALL_REDIR instead.
- STALL
  - Same as RUN, except `pc_enable`=1 returns to RUN.
  - `branch_taken` with `pc_enable`=0 goes to STALL_REDIR.
- STALL_REDIR
  - PC/nPC hold; latched target is kept.
  - A new `branch_taken` while still stalled overwrites the latch (last wins).
  - On `pc_enable`=1: if `branch_taken`=1, the live target is used; otherwise the latched target is used. Either way PC←nPC, nPC←target, latch cleared, go to RUN.
- IF/ID, outside BOOT
  - `load_enable`=1: `if_id_instr`←`imem_data`, `if_id_pc`←`pc_out`, `if_id_valid`←1.
  - `load_enable`=0: all three hold.
  - `load_enable` and `pc_enable` are independent; no cross-checking.
- Arithmetic: nPC+4 is modulo 2^32 (32'hFFFFFFFC+4 = 0). `imem_addr` truncates the PC and wraps silently.

## Timing
- Reset values, asynchronous on the falling edge of `reset`:
  - `pc_out`=RESET_PC, `npc_out`=RESET_NPC, `imem_addr`=RESET_PC[ADDR_W-1:0].
  - `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0.
  - `redirect_pending`=0, state=BOOT.
- Reset asserted mid-stall or mid-redirect discards the latched target.
- Fetch latency: instruction at PC appears on `if_id_instr` one edge later.
- Redirect: the delay-slot instruction (old nPC) is fetched the cycle after `branch_taken`. The target is fetched the cycle after that.
- `redirect_pending` is registered: high exactly in STALL_REDIR.

## Structure
- Shared pipeline package holds:
  - state enum (BOOT/RUN/STALL/STALL_REDIR);
  - `NOP_INSTR`=32'h0;
  - default `RESET_PC`/`RESET_NPC`;
  - `PC_INC`=32'd4.
- One sub-module, `redirect_latch`: target register plus valid bit, with load/clear/priority mux. The FSM, PC/nPC and IF/ID registers stay in `fetch_unit`.

## Test plan
- Reset low 3 cycles, then high, all enables 1, imem[n]=n → BOOT gives valid=0. Then `if_id_pc` sequences 0, 4, 8, … with valid=1.
- At PC=8, nPC=12, pulse `branch_taken` with target 32'h40 → next PC=12 (delay slot), then PC=0x40, nPC=0x44.
- `pc_enable`=0 for 3 cycles at PC=16 with `branch_taken` pulsed once (target 0x80) → `redirect_pending`=1 and PC holds 16. Release → PC=20, then 0x80; pending clears.
- Stalled redirect latched (0x80), then release together with live `branch_taken` target 0xC0 → nPC=0xC0 (live wins).
- `load_enable`=0 with `pc_enable`=1 → IF/ID outputs frozen while PC advances. Separately, RESET_NPC=32'hFFFFFFFC → nPC wraps to 0.
- Assert `reset` low during STALL_REDIR → all outputs return to reset values immediately; state goes to BOOT.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants
package fetch_unit_pkg;
  typedef enum logic [1:0] {BOOT, RUN, STALL, STALL_REDIR} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] DEF_RESET_PC = 32'd0;
  localparam logic [31:0] DEF_RESET_NPC = 32'd4;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_unit_redirect_latch.sv
// redirect_latch: holds a branch target seen during a stall; live target takes priority
module redirect_latch (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic        sel_live,
  input  logic [31:0] live_target,
  output logic [31:0] target,
  output logic        pending
);
  logic [31:0] held;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      held <= '0;
      pending <= 1'b0;
    end else if (load) begin
      held <= live_target & ~32'h3;
      pending <= 1'b1;
    end else if (clear) begin
      held <= '0;
      pending <= 1'b0;
    end
  assign target = sel_live ? live_target & ~32'h3 : held;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/nPC sequencing with delayed-branch redirect, stall handling and IF/ID register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] RESET_NPC = DEF_RESET_NPC,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_enable,
  input  logic              load_enable,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       pc_out,
  output logic [31:0]       npc_out,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              if_id_valid,
  output logic              redirect_pending
);
  state_t state, state_nx;
  logic [31:0] target, npc_nx;
  logic adv, load, clear;
  assign adv = pc_enable && state != BOOT;
  assign load = !pc_enable && branch_taken && state != BOOT;
  assign clear = adv && state == STALL_REDIR;
  redirect_latch u_latch (
    .clk(clk), .reset(reset), .load(load), .clear(clear), .sel_live(branch_taken),
    .live_target(branch_target), .target(target), .pending(redirect_pending)
  );
  always_comb begin
    state_nx = (state == BOOT || pc_enable) ? RUN :
               branch_taken ? STALL_REDIR :
               state == RUN ? STALL : state;
    npc_nx = (branch_taken || state == STALL_REDIR) ? target : npc_out + PC_INC;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= BOOT;
      pc_out <= RESET_PC;
      npc_out <= RESET_NPC;
      if_id_instr <= NOP_INSTR;
      if_id_pc <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (adv) begin
        pc_out <= npc_out;
        npc_out <= npc_nx;
      end
      if (state == BOOT) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (load_enable) begin
        if_id_instr <= imem_data;
        if_id_pc <= pc_out;
        if_id_valid <= 1'b1;
      end
    end
  assign imem_addr = pc_out[ADDR_W-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of sequencing, delayed branch, stalled redirect, IF/ID hold, wrap and reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset, pc_enable, load_enable, branch_taken;
  logic [31:0] branch_target, imem_data, pc_out, npc_out, if_id_instr, if_id_pc;
  logic [8:0] imem_addr, imem_addr2;
  logic if_id_valid, redirect_pending;
  logic [31:0] pc2, npc2, instr2, ifpc2;
  logic valid2, pend2;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign imem_data = 32'h1000_0000 | {23'h0, imem_addr};
  fetch_unit dut (
    .clk(clk), .reset(reset), .pc_enable(pc_enable), .load_enable(load_enable),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .pc_out(pc_out), .npc_out(npc_out), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .redirect_pending(redirect_pending)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .RESET_NPC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .pc_enable(pc_enable), .load_enable(load_enable),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem_addr(imem_addr2),
    .imem_data(32'h0), .pc_out(pc2), .npc_out(npc2), .if_id_instr(instr2),
    .if_id_pc(ifpc2), .if_id_valid(valid2), .redirect_pending(pend2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; pc_enable = 1'b1; load_enable = 1'b1; branch_taken = 1'b0; branch_target = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_npc", npc_out, 32'h4);
    chk("rst_addr", {23'h0, imem_addr}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_ifpc", if_id_pc, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_pend", {31'h0, redirect_pending}, 32'h0);
    chk("wrap_rst_npc", npc2, 32'hFFFF_FFFC);
    tick; tick; tick;
    reset = 1'b1;
    tick;
    chk("boot_pc", pc_out, 32'h0);
    chk("boot_npc", npc_out, 32'h4);
    chk("boot_valid", {31'h0, if_id_valid}, 32'h0);
    chk("boot_instr", if_id_instr, 32'h0);
    chk("wrap_boot_pc", pc2, 32'hFFFF_FFF8);
    tick;
    chk("run1_pc", pc_out, 32'h4);
    chk("run1_ifpc", if_id_pc, 32'h0);
    chk("run1_instr", if_id_instr, 32'h1000_0000);
    chk("run1_valid", {31'h0, if_id_valid}, 32'h1);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_npc", npc2, 32'h0);
    chk("wrap_addr", {23'h0, imem_addr2}, 32'h1FC);
    tick;
    chk("run2_pc", pc_out, 32'h8);
    chk("run2_npc", npc_out, 32'hC);
    chk("run2_ifpc", if_id_pc, 32'h4);
    branch_taken = 1'b1; branch_target = 32'h43;
    tick;
    branch_taken = 1'b0;
    chk("br_slot_pc", pc_out, 32'hC);
    chk("br_slot_npc", npc_out, 32'h40);
    chk("br_slot_ifpc", if_id_pc, 32'h8);
    tick;
    chk("br_tgt_pc", pc_out, 32'h40);
    chk("br_tgt_npc", npc_out, 32'h44);
    chk("br_tgt_instr", if_id_instr, 32'h1000_000C);
    branch_taken = 1'b1; branch_target = 32'h10;
    tick;
    branch_taken = 1'b0;
    tick;
    chk("back16_pc", pc_out, 32'h10);
    chk("back16_npc", npc_out, 32'h14);
    pc_enable = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    tick;
    branch_taken = 1'b0;
    chk("st1_pc", pc_out, 32'h10);
    chk("st1_pend", {31'h0, redirect_pending}, 32'h1);
    tick; tick;
    chk("st3_pc", pc_out, 32'h10);
    chk("st3_npc", npc_out, 32'h14);
    chk("st3_pend", {31'h0, redirect_pending}, 32'h1);
    pc_enable = 1'b1;
    tick;
    chk("rel_pc", pc_out, 32'h14);
    chk("rel_npc", npc_out, 32'h80);
    chk("rel_pend", {31'h0, redirect_pending}, 32'h0);
    tick;
    chk("rel_tgt_pc", pc_out, 32'h80);
    chk("rel_tgt_npc", npc_out, 32'h84);
    pc_enable = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    tick;
    chk("live_st_pend", {31'h0, redirect_pending}, 32'h1);
    pc_enable = 1'b1; branch_target = 32'hC0;
    tick;
    branch_taken = 1'b0;
    chk("live_pc", pc_out, 32'h84);
    chk("live_npc", npc_out, 32'hC0);
    chk("live_pend", {31'h0, redirect_pending}, 32'h0);
    chk("live_ifpc", if_id_pc, 32'h80);
    load_enable = 1'b0;
    tick; tick;
    chk("ld_hold_pc", pc_out, 32'hC4);
    chk("ld_hold_ifpc", if_id_pc, 32'h80);
    chk("ld_hold_instr", if_id_instr, 32'h1000_0080);
    chk("ld_hold_valid", {31'h0, if_id_valid}, 32'h1);
    load_enable = 1'b1;
    tick;
    chk("ld_resume_ifpc", if_id_pc, 32'hC4);
    chk("ld_resume_addr", {23'h0, imem_addr}, 32'hC8);
    pc_enable = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    tick;
    branch_taken = 1'b0;
    chk("pre_rst_pend", {31'h0, redirect_pending}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_npc", npc_out, 32'h4);
    chk("mid_rst_pend", {31'h0, redirect_pending}, 32'h0);
    chk("mid_rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("mid_rst_ifpc", if_id_pc, 32'h0);
    chk("mid_rst_addr", {23'h0, imem_addr}, 32'h0);
    tick;
    reset = 1'b1; pc_enable = 1'b1;
    tick;
    chk("reboot_pc", pc_out, 32'h0);
    chk("reboot_valid", {31'h0, if_id_valid}, 32'h0);
    tick;
    chk("rerun_pc", pc_out, 32'h4);
    chk("rerun_npc", npc_out, 32'h8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
